// File: rtl/duart_pkg.sv
// Baud-rate tables, select-code constants and divisor helper shared by the
// MC68681 channel baud-rate generator.
package duart_pkg;

    localparam int unsigned BRG_DIV_W = 16;
    typedef logic [BRG_DIV_W-1:0] brg_div_t;

    localparam logic [3:0] BAUD_DISABLED_D = 4'hD;
    localparam logic [3:0] BAUD_DISABLED_E = 4'hE;
    localparam logic [3:0] BAUD_DISABLED_F = 4'hF;
    localparam logic [3:0] BAUD_CODE_9600  = 4'hB;
    localparam logic [7:0] CSR_RESET       = {BAUD_CODE_9600, BAUD_CODE_9600};

    // Baud rate times ten so that 134.5 baud stays an integer.
    localparam int unsigned BAUD_X10_SET1 [13] = '{
        500, 1100, 1345, 2000, 3000, 6000, 12000, 10500,
        24000, 48000, 72000, 96000, 384000
    };
    localparam int unsigned BAUD_X10_SET2 [13] = '{
        750, 1100, 1345, 1500, 3000, 6000, 12000, 20000,
        24000, 48000, 18000, 96000, 192000
    };

    function automatic logic code_disabled(input logic [3:0] code);
        return code inside {BAUD_DISABLED_D, BAUD_DISABLED_E, BAUD_DISABLED_F};
    endfunction

    // Only ever called with constant arguments, so it folds to a table entry.
    function automatic brg_div_t baud_div(input logic [3:0] code, input logic set,
                                          input int unsigned clk_hz);
        longint unsigned b;
        longint unsigned d;
        if (code_disabled(code)) begin
            return brg_div_t'(1);
        end
        b = set ? 64'(BAUD_X10_SET2[code]) : 64'(BAUD_X10_SET1[code]);
        d = (64'(clk_hz) * 64'd10) / (64'd16 * b);
        if (d == 64'd0) begin
            d = 64'd1;
        end
        return brg_div_t'(d);
    endfunction

endpackage

// File: rtl/brg_counter.sv
// Reloading down-counter producing a registered one-cycle tick every div cycles.
module brg_counter #(
    parameter int unsigned      DIV_W   = 16,
    parameter logic [DIV_W-1:0] RST_CNT = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (load) begin
            cnt_d = div - DIV_W'(1);
        end else if (enable) begin
            if (cnt_q == '0) begin
                cnt_d  = div - DIV_W'(1);
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            cnt_q  <= RST_CNT;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/duart_baud_gen.sv
// Clock Select Register plus independent RX/TX 16x baud tick generators for one
// DUART channel; ACR[7] picks the baud table set.
module duart_baud_gen
    import duart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 3686400,
    parameter int unsigned DIV_W  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       rw,
    input  logic       acr7,
    input  logic [7:0] data,
    output logic       RxTick16,
    output logic       TxTick16,
    output logic [7:0] csr
);

    localparam logic [DIV_W-1:0] RST_CNT =
        DIV_W'(baud_div(BAUD_CODE_9600, 1'b0, CLK_HZ)) - DIV_W'(1);

    logic [7:0]       csr_q, csr_d;
    logic             acr7_q;
    logic             wr_csr, load;
    logic [DIV_W-1:0] div_tbl [32];
    logic [DIV_W-1:0] rx_div, tx_div;

    // Index is {set, code}; every entry is an elaboration-time constant.
    for (genvar i = 0; i < 32; i++) begin : g_div_tbl
        localparam logic [DIV_W-1:0] DIV = DIV_W'(baud_div(4'(i % 16), 1'(i / 16), CLK_HZ));
        assign div_tbl[i] = DIV;
    end

    assign wr_csr = cs & ~rw;
    assign csr_d  = wr_csr ? data : csr_q;
    // A write and an ACR[7] change on one edge collapse into a single load.
    assign load   = wr_csr | (acr7 != acr7_q);
    assign rx_div = div_tbl[{acr7, csr_d[7:4]}];
    assign tx_div = div_tbl[{acr7, csr_d[3:0]}];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csr_q  <= CSR_RESET;
            acr7_q <= 1'b0;
        end else begin
            csr_q  <= csr_d;
            acr7_q <= acr7;
        end
    end

    brg_counter #(.DIV_W(DIV_W), .RST_CNT(RST_CNT)) u_rx_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (!code_disabled(csr_d[7:4])),
        .div    (rx_div),
        .tick   (RxTick16)
    );

    brg_counter #(.DIV_W(DIV_W), .RST_CNT(RST_CNT)) u_tx_cnt (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (!code_disabled(csr_d[3:0])),
        .div    (tx_div),
        .tick   (TxTick16)
    );

    assign csr = csr_q;

endmodule

// File: tb/tb_duart_baud_gen.sv
// Directed bench for duart_baud_gen at the default 3.6864 MHz clock.
module tb_duart_baud_gen;

    logic       clk;
    logic       reset;
    logic       cs;
    logic       rw;
    logic       acr7;
    logic [7:0] data;
    logic       RxTick16;
    logic       TxTick16;
    logic [7:0] csr;

    int checks = 0;
    int errors = 0;

    duart_baud_gen dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .rw       (rw),
        .acr7     (acr7),
        .data     (data),
        .RxTick16 (RxTick16),
        .TxTick16 (TxTick16),
        .csr      (csr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_csr(input logic [7:0] d);
        cs   = 1'b1;
        rw   = 1'b0;
        data = d;
        step();
        cs   = 1'b0;
        rw   = 1'b1;
    endtask

    // Edge number (counted from the next edge) of the first tick on each output; 0 means no tick within max_edges.
    task automatic measure(input int max_edges, output int rx_n, output int tx_n);
        rx_n = 0;
        tx_n = 0;
        for (int n = 1; n <= max_edges; n++) begin
            step();
            if (rx_n == 0 && RxTick16) rx_n = n;
            if (tx_n == 0 && TxTick16) tx_n = n;
            if (rx_n != 0 && tx_n != 0) break;
        end
    endtask

    initial begin
        int rx_n;
        int tx_n;
        reset = 1'b1;
        cs    = 1'b0;
        rw    = 1'b1;
        acr7  = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_csr", 32'(csr), 32'h0BB);
        chk("reset_rx_tick", 32'(RxTick16), 32'd0);
        chk("reset_tx_tick", 32'(TxTick16), 32'd0);
        reset = 1'b0;

        // Idle after reset: 9600 baud on both sides
        measure(100, rx_n, tx_n);
        chk("idle_rx_first", 32'(rx_n), 32'd24);
        chk("idle_tx_first", 32'(tx_n), 32'd24);
        measure(100, rx_n, tx_n);
        chk("idle_rx_period", 32'(rx_n), 32'd24);
        chk("idle_tx_period", 32'(tx_n), 32'd24);

        // RX 1200, TX 9600
        write_csr(8'h6B);
        chk("wr6b_csr", 32'(csr), 32'h06B);
        chk("wr6b_no_tick", 32'({RxTick16, TxTick16}), 32'd0);
        measure(300, rx_n, tx_n);
        chk("wr6b_rx_period", 32'(rx_n), 32'd192);
        chk("wr6b_tx_period", 32'(tx_n), 32'd24);

        // 38400 in set 1, then ACR[7] toggle on the edge where the count hits 0
        write_csr(8'hCC);
        measure(50, rx_n, tx_n);
        chk("wrcc_rx_period", 32'(rx_n), 32'd6);
        chk("wrcc_tx_period", 32'(tx_n), 32'd6);
        repeat (5) step();
        acr7 = 1'b1;
        step();
        chk("acr7_toggle_no_tick", 32'({RxTick16, TxTick16}), 32'd0);
        measure(50, rx_n, tx_n);
        chk("set2_rx_period", 32'(rx_n), 32'd12);
        chk("set2_tx_period", 32'(tx_n), 32'd12);

        // RX disabled, TX 134.5 baud
        write_csr(8'hD2);
        chk("wrd2_csr", 32'(csr), 32'h0D2);
        measure(2000, rx_n, tx_n);
        chk("wrd2_rx_silent", 32'(rx_n), 32'd0);
        chk("wrd2_tx_period", 32'(tx_n), 32'd1713);

        // Write and ACR[7] change on one edge: new data with new set
        acr7 = 1'b0;
        write_csr(8'hCC);
        measure(50, rx_n, tx_n);
        chk("simul_rx_period", 32'(rx_n), 32'd6);
        chk("simul_tx_period", 32'(tx_n), 32'd6);

        // Write on the edge where the count is 0
        repeat (5) step();
        write_csr(8'hBB);
        chk("wr_at_zero_no_tick", 32'({RxTick16, TxTick16}), 32'd0);
        chk("wr_at_zero_csr", 32'(csr), 32'h0BB);
        measure(100, rx_n, tx_n);
        chk("wr_at_zero_rx_next", 32'(rx_n), 32'd24);
        chk("wr_at_zero_tx_next", 32'(tx_n), 32'd24);

        // Read cycle leaves CSR alone
        cs   = 1'b1;
        rw   = 1'b1;
        data = 8'h00;
        step();
        cs   = 1'b0;
        chk("read_keeps_csr", 32'(csr), 32'h0BB);

        // 300 baud, then asynchronous reset while the ticks are high
        write_csr(8'h44);
        measure(1000, rx_n, tx_n);
        chk("wr44_rx_period", 32'(rx_n), 32'd768);
        chk("wr44_tx_period", 32'(tx_n), 32'd768);
        chk("pre_reset_tick", 32'(TxTick16), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_ticks", 32'({RxTick16, TxTick16}), 32'd0);
        chk("async_reset_csr", 32'(csr), 32'h0BB);
        @(posedge clk);
        #1;
        reset = 1'b0;
        measure(100, rx_n, tx_n);
        chk("post_reset_rx_first", 32'(rx_n), 32'd24);
        chk("post_reset_tx_first", 32'(tx_n), 32'd24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/duart_baud_gen.md
# duart_baud_gen

- Baud-rate generator and Clock Select Register (CSR) for one MC68681 channel.
- Sits directly upstream of `UART`. It supplies independent 16x-rate receive and transmit clock-enable pulses, which `UART` uses to sample RX and shift TX.
- CSR is write-only and shares the SRA/CSR select: a read at that select returns SRA (driven by `SRA_CRA`), and a write loads CSR here.
- ACR[7] selects between baud table set 1 and set 2.

## Interface

Parameters:
- `CLK_HZ`, 3686400: input clock frequency in Hz; all divisors are derived from it.
- `DIV_W`, 16: width of the divisor counters.

Ports:
- `clk`  in  1  system clock; all state is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cs`  in  1  SRA/CSR select (active high, already decoded).
- `rw`  in  1  1 = read (ignored by this block), 0 = write CSR.
- `acr7`  in  1  baud set select: 0 = set 1, 1 = set 2.
- `data`  in  8  CPU data bus. CSR[7:4] is the RX select code; CSR[3:0] is the TX select code.
- `RxTick16`  out  1  one-cycle pulse at 16x the RX baud rate.
- `TxTick16`  out  1  one-cycle pulse at 16x the TX baud rate.
- `csr`  out  8  current CSR value (debug/status).

## Operation

**CSR write**
- When `cs=1` and `rw=0` at a rising edge, `csr <= data`.
- `cs=1` with `rw=1` has no effect.

**Baud select codes**
- Set 1 (`acr7=0`), codes 0–C: 50, 110, 134.5, 200, 300, 600, 1200, 1050, 2400, 4800, 7200, 9600, 38400.
- Set 2 (`acr7=1`), codes 0–C: 75, 110, 134.5, 150, 300, 600, 1200, 2000, 2400, 4800, 1800, 9600, 19200.
- Codes D, E and F (timer / IP4 external clocks) are not supported. They select "disabled": the counter holds its value and the tick stays 0.

**Divisor**
- `div = (CLK_HZ*10) / (16*baud_x10)`, integer division, truncated.
- `baud_x10` is the baud rate times ten, so 134.5 is expressed as 1345.
- Each divisor is a constant from the package function and must fit in `DIV_W`; it is clamped to a minimum of 1.

**Counters**
- There are two independent down-counters, RX and TX. Each is selected by its own nibble, and both use the same `acr7`.
- Per edge, in priority order:
  - If a load event occurs: `cnt <= div-1`, tick <= 0.
  - Else if the code is disabled: hold `cnt`, tick <= 0.
  - Else if `cnt == 0`: `cnt <= div-1`, tick <= 1.
  - Else: `cnt <= cnt-1`, tick <= 0.
- A load event is:
  - a CSR write (loads both counters using the new data), or
  - any change of `acr7`, detected against a registered copy `acr7_q`.

## Timing

**Reset values**
- `csr = 8'hBB` (9600 baud for both RX and TX).
- `acr7_q = 0`.
- Both counters = `div(9600, set 1) - 1` (23 at the default `CLK_HZ`).
- `RxTick16 = 0`, `TxTick16 = 0`.

**Tick timing**
- Ticks are registered outputs.
- After a load at edge E, the first tick is high for exactly one cycle following edge E+`div`. After that, ticks repeat every `div` cycles.
- `div=1` gives a tick on every cycle after the first.

**Write timing**
- A CSR write takes effect at the edge where it is sampled.
- No tick is issued on that edge, even if the old count had reached 0. A partial old period is discarded.

**Simultaneous events**
- A CSR write and an `acr7` change on the same edge produce a single load, using the new data and the new `acr7`.

**Reset**
- Assertion of `reset` mid-period clears both ticks immediately, asynchronously, and restores all reset values.
- After release, the first tick follows the normal load timing, counting from the first rising edge after release.

## Structure

- Package `duart_pkg` holds:
  - baud code constants (`BAUD_DISABLED_D`/`_E`/`_F`);
  - the two 13-entry `baud_x10` tables;
  - function `baud_div(code, set, clk_hz)` returning a `DIV_W`-bit divisor.
- Sub-module `brg_counter` (ports: `clk`, `reset`, `load`, `enable`, `div`, `tick`) is instantiated twice, once for RX and once for TX.
- The top level contains only the CSR register, `acr7_q` and the load detect.

## Test plan

1. Release reset and hold inputs idle → `csr=8'hBB`. `RxTick16` and `TxTick16` pulse together every 24 cycles; the first pulse is high during cycle 24 after the first edge.
2. Write `8'h6B` with `acr7=0` → RX period 192 cycles (1200 baud), TX period 24 cycles. Both counters restart at the write edge.
3. Write `8'hCC`, then toggle `acr7` 0→1 mid-period → period is 6 cycles (38400) before the toggle. After the toggle both counters restart and the period is 12 cycles (19200), with no tick on the toggle edge.
4. Write `8'hD2` → `RxTick16` stays 0 indefinitely. TX period is 1713 cycles (134.5 baud).
5. Write at the exact edge where `cnt==0` → no tick on that edge; the next tick comes `div` cycles later. A read (`cs=1`, `rw=1`) with `data=8'h00` leaves `csr` unchanged.
6. Assert `reset` for one cycle mid-period with `csr=8'h44` → ticks drop to 0 asynchronously. After release `csr=8'hBB` and the 24-cycle period resumes from a full count.
